// File: rtl/serial_shifter_pkg.sv
// Shared types and defaults for the serial right shifter.
// Optional feature macro used by the top: SERIAL_SHIFTER_EARLY_DONE_EN.
package serial_shifter_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;
  localparam int NUM_STAGES  = DEF_SHAMT_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_shifter_sra_stage.sv
// One power-of-two right-shift stage: shifts by 2^stage when enabled,
// filling the vacated top bits with 'fill'.
module sra_stage #(
  parameter int WIDTH = 32,
  parameter int STG_W = 3
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [STG_W-1:0] stage,
  input  logic             enable,
  input  logic             fill,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    // Shifting the complement and inverting back yields a ones fill.
    if (fill) shifted = ~((~data_in) >> (32'd1 << stage));
    else      shifted = data_in >> (32'd1 << stage);
    data_out = enable ? shifted : data_in;
  end

endmodule

// File: rtl/serial_shifter_sra.sv
// Multi-cycle SRL/SRA: one power-of-two stage per clock, largest first.
// SERIAL_SHIFTER_EARLY_DONE_EN skips stages that cannot change the result.
module serial_shifter_sra
  import serial_shifter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = NUM_STAGES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_A,
  input  logic [SHAMT_W-1:0] in_shift,
  input  logic               arith,
  output logic               busy,
  output logic               data_ready,
  output logic [WIDTH-1:0]   result,
  output state_e             dbg_state
);

  localparam int STG_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(SHAMT_W - 1);

  // Handshake: start is sampled only in IDLE or DONE; data_ready is a
  // one-cycle pulse in DONE; busy is high only in SHIFT; never both.

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] amt_q, amt_d;
  logic               fill_q, fill_d;
  logic [STG_W-1:0]   stage_q, stage_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic [WIDTH-1:0]   stage_out;
  logic [STG_W-1:0]   start_stage;
  logic               last_stage;

`ifdef SERIAL_SHIFTER_EARLY_DONE_EN
  logic [SHAMT_W-1:0] low_mask;

  function automatic logic [STG_W-1:0] msb_index(input logic [SHAMT_W-1:0] a);
    logic [STG_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (a[i]) idx = STG_W'(i);
    end
    return idx;
  endfunction
`endif

  sra_stage #(.WIDTH(WIDTH), .STG_W(STG_W)) u_stage (
    .data_in  (work_q),
    .stage    (stage_q),
    .enable   (amt_q[stage_q]),
    .fill     (fill_q),
    .data_out (stage_out)
  );

  always_comb begin
`ifdef SERIAL_SHIFTER_EARLY_DONE_EN
    // Stop once no lower amount bit remains to be applied.
    low_mask    = (SHAMT_W'(1) << stage_q) - SHAMT_W'(1);
    last_stage  = (stage_q == '0) || ((amt_q & low_mask) == '0);
    start_stage = msb_index(in_shift);
`else
    last_stage  = (stage_q == '0);
    start_stage = LAST_STAGE;
`endif
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    amt_d    = amt_q;
    fill_d   = fill_q;
    stage_d  = stage_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          work_d  = in_A;
          amt_d   = in_shift;
          fill_d  = arith & in_A[WIDTH-1];
          stage_d = start_stage;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        work_d = stage_out;
        if (last_stage) begin
          result_d = stage_out;
          state_d  = S_DONE;
        end else begin
          stage_d = stage_q - STG_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      work_q   <= '0;
      amt_q    <= '0;
      fill_q   <= 1'b0;
      stage_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      amt_q    <= amt_d;
      fill_q   <= fill_d;
      stage_q  <= stage_d;
      result_q <= result_d;
    end
  end

  assign busy       = (state_q == S_SHIFT);
  assign data_ready = (state_q == S_DONE);
  assign result     = result_q;
  assign dbg_state  = state_q;

endmodule
